// File: rtl/ram_fir_pkg.sv
// Shared types and width helpers for the RAM-backed FIR controller.
package ram_fir_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    WRITE,
    READ,
    DRAIN
  } state_t;

  // Full-precision product of one sample and one coefficient.
  function automatic int prod_width(input int dwidth, input int cwidth);
    return dwidth + cwidth;
  endfunction

  // Accumulator width: product plus AWIDTH growth bits, so no sum can overflow.
  function automatic int acc_width(input int dwidth, input int cwidth, input int awidth);
    return dwidth + cwidth + awidth;
  endfunction

  // Coefficient index width, never narrower than one bit.
  function automatic int tap_index_width(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/ram_fir_ctrl_if.sv
// Sample RAM (write port + registered read port) and coefficient ROM bus.
interface ram_fir_ctrl_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 9,
  parameter int CWIDTH = 16,
  parameter int KWIDTH = 4
);

  logic [DWIDTH-1:0] ram_wrdata;
  logic [AWIDTH-1:0] ram_wraddr;
  logic              ram_wren;
  logic [AWIDTH-1:0] ram_rdaddr;
  logic [DWIDTH-1:0] ram_rddata;
  logic [KWIDTH-1:0] coef_addr;
  logic [CWIDTH-1:0] coef;

  modport master (
    output ram_wrdata,
    output ram_wraddr,
    output ram_wren,
    output ram_rdaddr,
    output coef_addr,
    input  ram_rddata,
    input  coef
  );

  modport slave (
    input  ram_wrdata,
    input  ram_wraddr,
    input  ram_wren,
    input  ram_rdaddr,
    input  coef_addr,
    output ram_rddata,
    output coef
  );

endinterface

// File: rtl/ram_fir_mac.sv
// Multiply-accumulate pipeline: read strobe -> data/coef arrive -> product
// register -> accumulator -> result register with a one-cycle valid strobe.
module ram_fir_mac
  import ram_fir_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int CWIDTH = 16,
  parameter int OWIDTH = 41
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     en,
  input  logic                     last,
  input  logic signed [DWIDTH-1:0] rd_data,
  input  logic signed [CWIDTH-1:0] coef,
  output logic signed [OWIDTH-1:0] result,
  output logic                     result_valid
);

  localparam int PWIDTH = prod_width(DWIDTH, CWIDTH);

  logic                     s1_valid;
  logic                     s1_last;
  logic                     s2_valid;
  logic                     s2_last;
  logic                     s3_last;
  logic signed [PWIDTH-1:0] prod;
  logic signed [OWIDTH-1:0] acc;

  // Track which cycles carry RAM/ROM data and register the signed product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      prod     <= '0;
    end else begin
      s1_valid <= en;
      s1_last  <= en && last;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      if (s1_valid) begin
        prod <= PWIDTH'(rd_data) * PWIDTH'(coef);
      end
    end
  end

  // Sign-extend and sum products; publish the total one cycle after the last add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      s3_last      <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      if (clear) begin
        acc <= '0;
      end else if (s2_valid) begin
        acc <= acc + OWIDTH'(prod);
      end
      s3_last      <= s2_valid && s2_last;
      result_valid <= s3_last;
      if (s3_last) begin
        result <= acc;
      end
    end
  end

endmodule

// File: rtl/ram_fir_ctrl.sv
// FIR controller: clears the sample RAM after reset, writes each accepted
// sample into a circular history buffer, reads back the newest TAPS samples
// alongside their coefficients and hands them to the MAC pipeline.
module ram_fir_ctrl
  import ram_fir_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 9,
  parameter int TAPS   = 16,
  parameter int CWIDTH = 16,
  parameter int OWIDTH = acc_width(DWIDTH, CWIDTH, AWIDTH),
  parameter int KWIDTH = tap_index_width(TAPS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DWIDTH-1:0]        sample_i,
  input  logic                     sample_valid_i,
  output logic                     ready_o,
  output logic signed [OWIDTH-1:0] result_o,
  output logic                     result_valid_o,
  ram_fir_ctrl_if.master           bus
);

  state_t              state;
  state_t              state_n;
  logic [AWIDTH-1:0]   wr_ptr;
  logic [KWIDTH-1:0]   tap_cnt;
  logic [DWIDTH-1:0]   sample_q;
  logic                last_tap;
  logic                mac_clear;
  logic                mac_en;

  assign last_tap  = (state == READ) && (tap_cnt == KWIDTH'(TAPS - 1));
  assign mac_en    = (state == READ);
  assign mac_clear = (state == READ) && (tap_cnt == '0);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= CLEAR;
    end else begin
      state <= state_n;
    end
  end

  // Next state and ready; the result cycle doubles as an accept slot.
  always_comb begin
    state_n = state;
    ready_o = 1'b0;
    case (state)
      CLEAR: begin
        if (wr_ptr == {AWIDTH{1'b1}}) begin
          state_n = IDLE;
        end
      end
      IDLE: begin
        ready_o = 1'b1;
        if (sample_valid_i) begin
          state_n = WRITE;
        end
      end
      WRITE: begin
        state_n = READ;
      end
      READ: begin
        if (last_tap) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (result_valid_o) begin
          ready_o = 1'b1;
          state_n = sample_valid_i ? WRITE : IDLE;
        end
      end
      default: begin
        state_n = CLEAR;
      end
    endcase
  end

  // Write pointer, tap counter and sample latch. During CLEAR the write
  // pointer walks every address and wraps back to 0, so it doubles as the
  // clear address counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      tap_cnt  <= '0;
      sample_q <= '0;
    end else begin
      if (ready_o && sample_valid_i) begin
        sample_q <= sample_i;
      end
      if ((state == CLEAR) || last_tap) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if ((state == READ) && !last_tap) begin
        tap_cnt <= tap_cnt + 1'b1;
      end else begin
        tap_cnt <= '0;
      end
    end
  end

  // RAM and ROM addressing; the clear write is held off while reset is asserted.
  always_comb begin
    bus.ram_wren   = 1'b0;
    bus.ram_wraddr = '0;
    bus.ram_wrdata = '0;
    bus.ram_rdaddr = '0;
    bus.coef_addr  = '0;
    case (state)
      CLEAR: begin
        bus.ram_wren   = ~rst_i;
        bus.ram_wraddr = wr_ptr;
      end
      WRITE: begin
        bus.ram_wren   = 1'b1;
        bus.ram_wraddr = wr_ptr;
        bus.ram_wrdata = sample_q;
      end
      READ: begin
        bus.ram_rdaddr = wr_ptr - AWIDTH'(tap_cnt);
        bus.coef_addr  = tap_cnt;
      end
      default: begin
      end
    endcase
  end

  ram_fir_mac #(
    .DWIDTH(DWIDTH),
    .CWIDTH(CWIDTH),
    .OWIDTH(OWIDTH)
  ) u_mac (
    .clk          (clk_i),
    .rst          (rst_i),
    .clear        (mac_clear),
    .en           (mac_en),
    .last         (last_tap),
    .rd_data      (bus.ram_rddata),
    .coef         (bus.coef),
    .result       (result_o),
    .result_valid (result_valid_o)
  );

endmodule

// File: tb/tb_ram_fir_ctrl.sv
// Testbench for ram_fir_ctrl: 16-word RAM model, coefficient ROM {1,2,3,4},
// scoreboards for RAM writes and filter results.
module tb_ram_fir_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int TP    = 4;
  localparam int CW    = 16;
  localparam int OW    = DW + CW + AW;
  localparam int KW    = 2;
  localparam int DEPTH = 16;

  typedef struct {
    int          cycle;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } write_exp_t;

  typedef struct {
    longint value;
    int     cycle;
  } result_exp_t;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b0;
  logic [DW-1:0]        sample_i = '0;
  logic                 sample_valid_i = 1'b0;
  logic                 ready_o;
  logic signed [OW-1:0] result_o;
  logic                 result_valid_o;

  ram_fir_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW), .CWIDTH(CW), .KWIDTH(KW)) bus();

  ram_fir_ctrl #(
    .DWIDTH(DW),
    .AWIDTH(AW),
    .TAPS  (TP),
    .CWIDTH(CW)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .ready_o        (ready_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .bus            (bus)
  );

  always #5 clk_i = ~clk_i;

  int checkCount = 0;
  int passCount = 0;
  int cycleCount = 0;
  int lastAcceptCycle = -100;
  int expWrPtr = 0;

  write_exp_t  writeQ[$];
  result_exp_t resultQ[$];
  write_exp_t  monW;
  result_exp_t monR;

  int     impIn[5]   = '{1, 0, 0, 0, 0};
  longint impExp[5]  = '{1, 2, 3, 4, 0};
  longint wrapExp[4] = '{2, 6, 12, 20};
  longint extExp[4]  = '{-32750, -98290, -196600, -327680};

  logic [DW-1:0] ramMem [DEPTH];
  bit            ramPrimed = 1'b0;

  function automatic logic [CW-1:0] coefAt(input logic [KW-1:0] k);
    return CW'(k) + 16'd1;
  endfunction

  // Cycle counter used to timestamp expected events.
  always @(posedge clk_i) cycleCount <= cycleCount + 1;

  // RAM model (registered read, old data on read-during-write) and ROM model.
  always @(posedge clk_i) begin
    if (!ramPrimed) begin
      for (int i = 0; i < DEPTH; i++) ramMem[i] <= 16'h5A00 + 16'(i);
      ramPrimed <= 1'b1;
    end else if (bus.ram_wren) begin
      ramMem[bus.ram_wraddr] <= bus.ram_wrdata;
    end
    bus.ram_rddata <= ramMem[bus.ram_rdaddr];
    bus.coef       <= coefAt(bus.coef_addr);
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
  endtask

  // Monitor: pops scoreboard entries whenever the DUT writes or presents a result.
  always @(negedge clk_i) begin
    if (bus.ram_wren) begin
      checkOutput("write_expected", longint'(writeQ.size() != 0), 1);
      if (writeQ.size() != 0) begin
        monW = writeQ.pop_front();
        checkOutput("write_addr", longint'(bus.ram_wraddr), longint'(monW.addr));
        checkOutput("write_data", longint'(bus.ram_wrdata), longint'(monW.data));
        checkOutput("write_cycle", cycleCount, monW.cycle);
      end
    end
    if (result_valid_o) begin
      checkOutput("result_expected", longint'(resultQ.size() != 0), 1);
      if (resultQ.size() != 0) begin
        monR = resultQ.pop_front();
        checkOutput("result_value", longint'(result_o), monR.value);
        checkOutput("result_cycle", cycleCount, monR.cycle);
      end
    end
    if (cycleCount > lastAcceptCycle && cycleCount <= lastAcceptCycle + 8) begin
      checkOutput("ready_busy", longint'(ready_o), 0);
    end
  end

  // Offer one sample (called at a negedge) and record what it must produce.
  task automatic applyStimulus(input int value, input longint expResult, input bit hold);
    int waited = 0;
    write_exp_t  w;
    result_exp_t r;
    sample_i = value[DW-1:0];
    sample_valid_i = 1'b1;
    while (!ready_o && waited < 40) begin
      @(negedge clk_i);
      waited++;
    end
    if (!ready_o) begin
      checkOutput("accept_timeout", longint'(ready_o), 1);
      sample_valid_i = 1'b0;
      return;
    end
    lastAcceptCycle = cycleCount;
    w.cycle = cycleCount + 1;
    w.addr  = AW'(expWrPtr);
    w.data  = value[DW-1:0];
    writeQ.push_back(w);
    r.value = expResult;
    r.cycle = cycleCount + 9;
    resultQ.push_back(r);
    expWrPtr = (expWrPtr + 1) % DEPTH;
    @(negedge clk_i);
    if (!hold) sample_valid_i = 1'b0;
  endtask

  // Release reset mid-cycle and expect the 16-word clear sweep.
  task automatic releaseReset();
    write_exp_t w;
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w.cycle = cycleCount + i;
      w.addr  = AW'(i);
      w.data  = '0;
      writeQ.push_back(w);
    end
    expWrPtr = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk_i);
      checkOutput("clear_ready", longint'(ready_o), 0);
    end
    @(negedge clk_i);
    checkOutput("clear_done_ready", longint'(ready_o), 1);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (resultQ.size() != 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("drain_pending", resultQ.size(), 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ready"}, longint'(ready_o), 0);
    checkOutput({tag, "_wren"}, longint'(bus.ram_wren), 0);
    checkOutput({tag, "_wraddr"}, longint'(bus.ram_wraddr), 0);
    checkOutput({tag, "_wrdata"}, longint'(bus.ram_wrdata), 0);
    checkOutput({tag, "_rdaddr"}, longint'(bus.ram_rdaddr), 0);
    checkOutput({tag, "_coef_addr"}, longint'(bus.coef_addr), 0);
    checkOutput({tag, "_result_valid"}, longint'(result_valid_o), 0);
    checkOutput({tag, "_result"}, longint'(result_o), 0);
  endtask

  initial begin
    #1 rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checkAllZero("reset");
    releaseReset();

    $display("[TB] impulse");
    for (int i = 0; i < 5; i++) applyStimulus(impIn[i], impExp[i], 1'b0);
    waitDrain();

    $display("[TB] wrap with constant 2");
    for (int i = 0; i < 20; i++) applyStimulus(2, (i < 4) ? wrapExp[i] : 64'sd20, 1'b0);
    waitDrain();

    $display("[TB] extremes with valid held high");
    for (int i = 0; i < 8; i++) applyStimulus(-32768, (i < 4) ? extExp[i] : -64'sd327680, i < 7);
    waitDrain();

    $display("[TB] reset during READ");
    applyStimulus(5, 0, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    checkAllZero("abort");
    void'(resultQ.pop_back());
    repeat (2) @(negedge clk_i);
    releaseReset();
    applyStimulus(7, 7, 1'b0);
    applyStimulus(0, 14, 1'b0);
    waitDrain();
    repeat (3) @(negedge clk_i);
    checkOutput("write_queue_empty", writeQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, actual running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
